// File: rtl/gmm_model_writeback_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gmm_model_writeback_if                                               |
// | Record stream sink plus Avalon-MM burst write master bundle.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface gmm_model_writeback_if #(
  parameter int DATA_W    = 153,
  parameter int MEM_W     = 256,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16
);
  localparam int c_BC_W = $clog2(BURST_LEN) + 1;

  logic                 snk_valid;
  logic [DATA_W-1:0]    snk_data;
  logic                 snk_ready;
  logic [ADDR_W-1:0]    avm_address;
  logic                 avm_write;
  logic [MEM_W-1:0]     avm_writedata;
  logic [c_BC_W-1:0]    avm_burstcount;
  logic [MEM_W/8-1:0]   avm_byteenable;
  logic                 avm_waitrequest;

  // master: the write-back block (stream sink, memory master)
  modport master (
    input  snk_valid, snk_data, avm_waitrequest,
    output snk_ready, avm_address, avm_write, avm_writedata,
           avm_burstcount, avm_byteenable
  );

  modport slave (
    output snk_valid, snk_data, avm_waitrequest,
    input  snk_ready, avm_address, avm_write, avm_writedata,
           avm_burstcount, avm_byteenable
  );
endinterface
`default_nettype wire

// File: rtl/gmm_model_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gmm_model_writeback                                                  |
// | Buffers per-pixel model records and writes them as Avalon-MM bursts. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module gmm_model_writeback #(
  parameter int DATA_W      = 153,
  parameter int MEM_W       = 256,
  parameter int ADDR_W      = 32,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int FRAME_WORDS = 2073600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 start,
  output logic                 busy,
  output logic                 frame_done,
  gmm_model_writeback_if.master bus
);
  localparam int c_BC_W    = $clog2(BURST_LEN) + 1;
  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_FCNT_W  = c_PTR_W + 1;
  localparam int c_CNT_W   = $clog2(FRAME_WORDS + 1);
  localparam int c_BYTES   = MEM_W / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_BURST = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_FCNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]   r_recv_cnt;
  logic [c_CNT_W-1:0]   r_sent_cnt;
  logic [ADDR_W-1:0]    r_base;
  logic [ADDR_W-1:0]    r_avm_address;
  logic                 r_avm_write;
  logic [c_BC_W-1:0]    r_avm_burstcount;
  logic [c_BC_W-1:0]    r_beats_left;
  logic                 r_busy;
  logic                 r_frame_done;

  logic                 w_snk_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [c_CNT_W-1:0]   w_remain;
  logic [c_BC_W-1:0]    w_len;
  logic                 w_fill_ok;
  logic                 w_start_ok;

  // Ready depends only on registered state, never on avm_waitrequest.
  assign w_snk_ready = r_busy && (r_count < c_FCNT_W'(FIFO_DEPTH)) &&
                       (r_recv_cnt != c_CNT_W'(FRAME_WORDS));
  assign w_push      = bus.snk_valid && w_snk_ready;
  assign w_pop       = r_avm_write && !bus.avm_waitrequest;
  assign w_start_ok  = (r_state == S_IDLE) && start;

  assign w_remain  = c_CNT_W'(FRAME_WORDS) - r_sent_cnt;
  assign w_len     = (w_remain < c_CNT_W'(BURST_LEN)) ? c_BC_W'(w_remain)
                                                      : c_BC_W'(BURST_LEN);
  assign w_fill_ok = 32'(r_count) >= 32'(w_len);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.snk_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || w_start_ok) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_recv_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_recv_cnt <= r_recv_cnt + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_base           <= '0;
      r_sent_cnt       <= '0;
      r_avm_address    <= '0;
      r_avm_write      <= 1'b0;
      r_avm_burstcount <= '0;
      r_beats_left     <= '0;
      r_busy           <= 1'b0;
      r_frame_done     <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base     <= base_addr;
            r_sent_cnt <= '0;
            r_busy     <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          // Wait until the whole burst is resident so avm_write never gaps.
          if (w_fill_ok) begin
            r_avm_address    <= r_base + ADDR_W'(r_sent_cnt) * ADDR_W'(c_BYTES);
            r_avm_burstcount <= w_len;
            r_beats_left     <= w_len;
            r_avm_write      <= 1'b1;
            r_state          <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_pop) begin
            r_sent_cnt   <= r_sent_cnt + 1'b1;
            r_beats_left <= r_beats_left - 1'b1;
            if (r_beats_left == c_BC_W'(1)) begin
              r_avm_write <= 1'b0;
              if (r_sent_cnt + 1'b1 == c_CNT_W'(FRAME_WORDS)) begin
                r_frame_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_state <= S_FILL;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy               = r_busy;
  assign frame_done         = r_frame_done;
  assign bus.snk_ready      = w_snk_ready;
  assign bus.avm_address    = r_avm_address;
  assign bus.avm_write      = r_avm_write;
  assign bus.avm_burstcount = r_avm_burstcount;
  assign bus.avm_byteenable = '1;

  generate
    if (MEM_W > DATA_W) begin : g_pad
      assign bus.avm_writedata = {{(MEM_W-DATA_W){1'b0}}, r_mem[r_rd_ptr]};
    end else begin : g_nopad
      assign bus.avm_writedata = r_mem[r_rd_ptr];
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_gmm_model_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gmm_model_writeback                                               |
// | Directed bench: 40-record frames, stalls, wrap, ignored start, reset.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_gmm_model_writeback;
  localparam int DATA_W      = 153;
  localparam int MEM_W       = 256;
  localparam int ADDR_W      = 32;
  localparam int BURST_LEN   = 16;
  localparam int FIFO_DEPTH  = 32;
  localparam int FRAME_WORDS = 40;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              frame_done;

  gmm_model_writeback_if #(.DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W),
                           .BURST_LEN(BURST_LEN)) bus ();

  gmm_model_writeback #(
    .DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH), .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .base_addr(base_addr), .start(start),
    .busy(busy), .frame_done(frame_done), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_value(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rec(input int unsigned i);
    return {25'(i), ~i, i * 32'd7, i ^ 32'hA5A5_5A5A, 32'hC0DE_0000 + i};
  endfunction

  // Source / stall generator state
  int unsigned src_seq = 0;
  int  frame_acc = 0, src_limit = 0, vmode = 0, wmode = 0, vcyc = 0, wcyc = 0;
  bit  src_en = 1'b0;

  always @(posedge clk) begin
    #1;
    vcyc++;
    wcyc++;
    bus.snk_valid = src_en && (frame_acc < src_limit) && (vmode == 0 || vcyc % 3 == 0);
    bus.snk_data  = rec(src_seq);
    case (wmode)
      1:       bus.avm_waitrequest = (wcyc % 2 == 1);
      2:       bus.avm_waitrequest = (wcyc < 70) ? 1'b1 : (wcyc % 2 == 1);
      default: bus.avm_waitrequest = 1'b0;
    endcase
  end

  // Monitor / scoreboard
  logic [DATA_W-1:0] sb_q[$];
  logic [ADDR_W-1:0] b_addr [8];
  int                b_cnt  [8];
  logic [ADDR_W-1:0] cur_addr;
  logic [4:0]        cur_cnt;
  int  n_beats, n_bursts, burst_left, gaps, occ, max_occ, stall_cyc, n_done, first_wr_acc;
  bit  seen_wr;

  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
      burst_left = 0;
      occ = 0;
    end else begin
      if (bus.snk_valid && !bus.snk_ready && busy && frame_acc < FRAME_WORDS) stall_cyc++;
      if (bus.snk_valid && bus.snk_ready) begin
        sb_q.push_back(bus.snk_data);
        src_seq++;
        frame_acc++;
        occ++;
      end
      if (frame_done) n_done++;
      if (bus.avm_write) begin
        if (!seen_wr) begin
          seen_wr = 1'b1;
          first_wr_acc = frame_acc;
        end
        if (burst_left == 0) begin
          if (n_bursts < 8) begin
            b_addr[n_bursts] = bus.avm_address;
            b_cnt[n_bursts]  = int'(bus.avm_burstcount);
          end
          n_bursts++;
          burst_left = int'(bus.avm_burstcount);
          cur_addr   = bus.avm_address;
          cur_cnt    = bus.avm_burstcount;
        end else begin
          check_value("addr_hold", bus.avm_address, cur_addr);
          check_value("bcnt_hold", bus.avm_burstcount, cur_cnt);
        end
        if (!bus.avm_waitrequest) begin
          if (sb_q.size() == 0) check_value("sb_underflow", 0, 1);
          else check_value("beat_data", bus.avm_writedata, {103'b0, sb_q.pop_front()});
          burst_left--;
          n_beats++;
          occ--;
        end
      end else if (burst_left > 0) begin
        gaps++;
      end
      if (occ > max_occ) max_occ = occ;
    end
  end

  task automatic start_frame(input logic [ADDR_W-1:0] base, input int vm, input int wm,
                             input int limit);
    @(posedge clk); #2;
    n_beats = 0; n_bursts = 0; gaps = 0; max_occ = 0; stall_cyc = 0; n_done = 0;
    seen_wr = 1'b0; first_wr_acc = 0; frame_acc = 0;
    vmode = vm; wmode = wm; wcyc = 0; src_limit = limit; src_en = 1'b1;
    base_addr = base;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!frame_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check_value({tag, "_timeout"}, (cyc < 3000), 1);
    @(negedge clk);
    check_value({tag, "_busy_low"}, busy, 0);
  endtask

  task automatic check_bursts(input string tag, input logic [ADDR_W-1:0] a0,
                              input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    check_value({tag, "_nbursts"}, n_bursts, 3);
    check_value({tag, "_addr0"}, b_addr[0], a0);
    check_value({tag, "_addr1"}, b_addr[1], a1);
    check_value({tag, "_addr2"}, b_addr[2], a2);
    check_value({tag, "_bc0"}, b_cnt[0], 16);
    check_value({tag, "_bc1"}, b_cnt[1], 16);
    check_value({tag, "_bc2"}, b_cnt[2], 8);
    check_value({tag, "_beats"}, n_beats, 40);
    check_value({tag, "_done_pulses"}, n_done, 1);
    check_value({tag, "_gaps"}, gaps, 0);
    check_value({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bus.snk_valid = 1'b0;
    bus.snk_data = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_busy", busy, 0);
    check_value("rst_frame_done", frame_done, 0);
    check_value("rst_snk_ready", bus.snk_ready, 0);
    check_value("rst_avm_write", bus.avm_write, 0);
    check_value("rst_avm_address", bus.avm_address, 0);
    check_value("rst_burstcount", bus.avm_burstcount, 0);
    check_value("rst_byteenable", bus.avm_byteenable, 32'hFFFF_FFFF);
    @(posedge clk); #2 rst = 1'b1;

    // Continuous input, no stalls
    start_frame(32'h0000_1000, 0, 0, 40);
    check_value("a_busy_high", busy, 1);
    wait_done("a");
    check_bursts("a", 32'h1000, 32'h1200, 32'h1400);

    // Waitrequest every other cycle
    start_frame(32'h0000_1000, 0, 1, 40);
    wait_done("b");
    check_bursts("b", 32'h1000, 32'h1200, 32'h1400);
    check_value("b_occ_bound", (max_occ <= FIFO_DEPTH), 1);

    // Long initial stall: FIFO fills to depth and the sink back-pressures
    start_frame(32'h0000_3000, 0, 2, 40);
    wait_done("c");
    check_bursts("c", 32'h3000, 32'h3200, 32'h3400);
    check_value("c_max_occ", max_occ, FIFO_DEPTH);
    check_value("c_sink_stalled", (stall_cyc > 0), 1);

    // Sparse input: no write until a whole burst is buffered
    start_frame(32'h0000_5000, 1, 0, 40);
    wait_done("d");
    check_bursts("d", 32'h5000, 32'h5200, 32'h5400);
    check_value("d_first_write_fill", first_wr_acc, 16);

    // Address wrap, then a clean frame from zero
    start_frame(32'hFFFF_FF00, 0, 0, 40);
    wait_done("e");
    check_bursts("e", 32'hFFFF_FF00, 32'h0000_0100, 32'h0000_0300);
    start_frame(32'h0000_0000, 0, 0, 40);
    wait_done("f");
    check_bursts("f", 32'h0000_0000, 32'h0000_0200, 32'h0000_0400);

    // Start while busy is ignored; a 41st record is refused
    start_frame(32'h0000_2000, 0, 1, 41);
    repeat (10) @(posedge clk);
    #2;
    base_addr = 32'h0000_9000;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("g");
    check_bursts("g", 32'h2000, 32'h2200, 32'h2400);
    repeat (5) @(negedge clk);
    check_value("g_extra_valid", bus.snk_valid, 1);
    check_value("g_extra_refused", bus.snk_ready, 0);
    check_value("g_accepted", frame_acc, 40);
    start_frame(32'h0000_6000, 0, 0, 40);
    wait_done("h");
    check_bursts("h", 32'h6000, 32'h6200, 32'h6400);

    // Reset in the middle of the first burst, then a full frame
    start_frame(32'h0000_7000, 0, 0, 40);
    cyc = 0;
    while (n_beats < 4 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check_value("i_reach_mid_burst", (cyc < 500), 1);
    check_value("i_write_active", bus.avm_write, 1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_value("i_rst_avm_write", bus.avm_write, 0);
    check_value("i_rst_busy", busy, 0);
    check_value("i_rst_snk_ready", bus.snk_ready, 0);
    @(posedge clk); #2 rst = 1'b1;
    start_frame(32'h0000_8000, 0, 0, 40);
    wait_done("j");
    check_bursts("j", 32'h8000, 32'h8200, 32'h8400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
